// File: rtl/jk_ff_monitor.sv
// jk_ff_monitor: in-circuit checker for a JK flip-flop cell.
// Predicts the cell's next state from the previous edge's J/K/Q, flags
// prediction errors and complement-pair violations, counts Q toggles and
// detects a Q output that has stopped changing. All outputs are registered.
module jk_ff_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned IDLE_LIMIT = 16
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             J,
  input  logic             K,
  input  logic             Q,
  input  logic             Qn,
  output logic             chk_valid,
  output logic             pred_err,
  output logic             pair_err,
  output logic             idle,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_LIMIT);

  // Next state of an ideal JK flip-flop given its inputs and current state.
  function automatic logic f_jk_next(input logic j, input logic k, input logic q);
    logic nq;
    case ({j, k})
      2'b00:   nq = q;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      2'b11:   nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // State and history registers
  state_t           r_state;
  logic             r_j_d;
  logic             r_k_d;
  logic             r_q_d;
  logic [CNT_W-1:0] r_idle_cnt;
  // Output registers
  logic             r_chk_valid;
  logic             r_pred_err;
  logic             r_pair_err;
  logic             r_idle;
  logic [CNT_W-1:0] r_toggle_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  // Next-state values
  state_t           w_state_nxt;
  logic             w_j_d_nxt;
  logic             w_k_d_nxt;
  logic             w_q_d_nxt;
  logic [CNT_W-1:0] w_idle_cnt_nxt;
  logic             w_pred_err_nxt;
  logic             w_pair_err_nxt;
  logic             w_idle_nxt;
  logic [CNT_W-1:0] w_toggle_cnt_nxt;
  logic [CNT_W-1:0] w_err_cnt_nxt;

  // Per-edge event decode
  logic             w_do_check;
  logic             w_leave_check;
  logic             w_exp_q;
  logic             w_mismatch;
  logic             w_toggle;
  logic             w_pair_bad;
  logic [CNT_W-1:0] w_idle_inc;

  // A compare only happens on an enabled edge while already armed.
  assign w_do_check    = (r_state == ST_CHECK) && en;
  assign w_leave_check = (r_state == ST_CHECK) && !en;
  assign w_exp_q       = f_jk_next(r_j_d, r_k_d, r_q_d);
  assign w_mismatch    = w_do_check && (Q != w_exp_q);
  assign w_toggle      = w_do_check && (Q != r_q_d);
  // Pair check is independent of arming: any enabled edge counts.
  assign w_pair_bad    = en && (Q == Qn);
  // Idle counter stops at the limit so it can never wrap back to zero.
  assign w_idle_inc    = (r_idle_cnt >= IDLE_LIM) ? IDLE_LIM : (r_idle_cnt + CNT_ONE);

  // Two-state arming FSM: IDLE arms on en, CHECK falls back when en drops.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (en) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // History capture: J/K/Q are recorded on every enabled edge for the next compare.
  always_comb begin
    w_j_d_nxt = r_j_d;
    w_k_d_nxt = r_k_d;
    w_q_d_nxt = r_q_d;
    if (en) begin
      w_j_d_nxt = J;
      w_k_d_nxt = K;
      w_q_d_nxt = Q;
    end else begin
      w_j_d_nxt = r_j_d;
      w_k_d_nxt = r_k_d;
      w_q_d_nxt = r_q_d;
    end
  end

  // Counters and sticky flags; clr overrides every same-edge update.
  always_comb begin
    w_idle_cnt_nxt   = r_idle_cnt;
    w_pred_err_nxt   = r_pred_err;
    w_pair_err_nxt   = r_pair_err;
    w_idle_nxt       = r_idle;
    w_toggle_cnt_nxt = r_toggle_cnt;
    w_err_cnt_nxt    = r_err_cnt;
    if (clr) begin
      w_idle_cnt_nxt   = CNT_ZERO;
      w_pred_err_nxt   = 1'b0;
      w_pair_err_nxt   = 1'b0;
      w_idle_nxt       = 1'b0;
      w_toggle_cnt_nxt = CNT_ZERO;
      w_err_cnt_nxt    = CNT_ZERO;
    end else begin
      if (w_mismatch) begin
        w_err_cnt_nxt  = f_sat_inc(r_err_cnt);
        w_pred_err_nxt = 1'b1;
      end else begin
        w_err_cnt_nxt  = r_err_cnt;
        w_pred_err_nxt = r_pred_err;
      end

      if (w_toggle) begin
        w_toggle_cnt_nxt = f_sat_inc(r_toggle_cnt);
      end else begin
        w_toggle_cnt_nxt = r_toggle_cnt;
      end

      if (w_pair_bad) begin
        w_pair_err_nxt = 1'b1;
      end else begin
        w_pair_err_nxt = r_pair_err;
      end

      if (w_do_check) begin
        if (Q == r_q_d) begin
          w_idle_cnt_nxt = w_idle_inc;
          w_idle_nxt     = (w_idle_inc >= IDLE_LIM);
        end else begin
          w_idle_cnt_nxt = CNT_ZERO;
          w_idle_nxt     = 1'b0;
        end
      end else if (w_leave_check) begin
        w_idle_cnt_nxt = CNT_ZERO;
        w_idle_nxt     = 1'b0;
      end else begin
        w_idle_cnt_nxt = r_idle_cnt;
        w_idle_nxt     = r_idle;
      end
    end
  end

  // Register bank; asynchronous active-low reset clears everything at once.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_j_d        <= 1'b0;
      r_k_d        <= 1'b0;
      r_q_d        <= 1'b0;
      r_idle_cnt   <= CNT_ZERO;
      r_chk_valid  <= 1'b0;
      r_pred_err   <= 1'b0;
      r_pair_err   <= 1'b0;
      r_idle       <= 1'b0;
      r_toggle_cnt <= CNT_ZERO;
      r_err_cnt    <= CNT_ZERO;
    end else begin
      r_state      <= w_state_nxt;
      r_j_d        <= w_j_d_nxt;
      r_k_d        <= w_k_d_nxt;
      r_q_d        <= w_q_d_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_chk_valid  <= (w_state_nxt == ST_CHECK);
      r_pred_err   <= w_pred_err_nxt;
      r_pair_err   <= w_pair_err_nxt;
      r_idle       <= w_idle_nxt;
      r_toggle_cnt <= w_toggle_cnt_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  assign chk_valid  = r_chk_valid;
  assign pred_err   = r_pred_err;
  assign pair_err   = r_pair_err;
  assign idle       = r_idle;
  assign toggle_cnt = r_toggle_cnt;
  assign err_cnt    = r_err_cnt;

endmodule
